// File: rtl/gnr_ctrl_pkg.sv
// Shared types for the gene-network attractor controller: FSM states,
// default counter width and the result record.
package gnr_ctrl_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int N_NODES_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_CHECK,
        ST_CYC_STEP,
        ST_CYC_CHECK,
        ST_DONE
    } state_e;

    // Result record at the default build widths; the controller declares
    // the same shape locally so it follows its own parameters.
    typedef struct packed {
        logic [CNT_W_DEF-1:0]   meet;
        logic [CNT_W_DEF-1:0]   period;
        logic [N_NODES_DEF-1:0] state;
        logic                   timeout;
    } gnr_res_t;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Loads an initial state into a dual-copy node array, runs Floyd cycle
// detection with step strobes, then measures the attractor period.
//
// state        | meaning
// IDLE         | waiting for an initial state offer
// LOAD         | node load strobe, step counter cleared
// STEP         | tortoise + hare step strobe
// CHECK        | compare copies after step, detect meet / timeout
// CYC_STEP     | hare-only step while measuring the period
// CYC_CHECK    | compare hare with the meet snapshot
// DONE         | result offered until accepted
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES   = N_NODES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STEPS = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_data,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] net_s0,
    input  logic [N_NODES-1:0] net_s1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic [N_NODES-1:0] res_state,
    output logic               res_timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    typedef struct packed {
        logic [CNT_W-1:0]   meet;
        logic [CNT_W-1:0]   period;
        logic [N_NODES-1:0] state;
        logic               timeout;
    } res_t;

    state_e             state_q, state_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    res_t               res_q, res_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_CNT) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        init_state_d = init_state_q;
        step_cnt_d   = step_cnt_q;
        per_cnt_d    = per_cnt_q;
        res_d        = res_q;
        // Everything freezes while start is low so a run resumes in place.
        if (start) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (init_valid) begin
                        init_state_d = init_data;
                        res_d        = '0;
                        state_d      = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    step_cnt_d = '0;
                    state_d    = ST_STEP;
                end
                ST_STEP: begin
                    step_cnt_d = sat_inc(step_cnt_q);
                    state_d    = ST_CHECK;
                end
                ST_CHECK: begin
                    // Tortoise only lines up with hare/2 on even step counts.
                    if (!step_cnt_q[0] && (net_s0 == net_s1)) begin
                        res_d.meet  = step_cnt_q;
                        res_d.state = net_s1;
                        per_cnt_d   = '0;
                        state_d     = ST_CYC_STEP;
                    end else if (step_cnt_q == MAX_CNT) begin
                        res_d.timeout = 1'b1;
                        res_d.period  = '0;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
                ST_CYC_STEP: begin
                    per_cnt_d = sat_inc(per_cnt_q);
                    state_d   = ST_CYC_CHECK;
                end
                ST_CYC_CHECK: begin
                    if (net_s1 == res_q.state) begin
                        res_d.period = per_cnt_q;
                        state_d      = ST_DONE;
                    end else if (per_cnt_q == MAX_CNT) begin
                        res_d.timeout = 1'b1;
                        res_d.period  = '0;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_CYC_STEP;
                    end
                end
                ST_DONE: begin
                    if (res_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            init_state_q <= '0;
            step_cnt_q   <= '0;
            per_cnt_q    <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            init_state_q <= init_state_d;
            step_cnt_q   <= step_cnt_d;
            per_cnt_q    <= per_cnt_d;
            res_q        <= res_d;
        end
    end

    assign init_ready  = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign reset_nos   = start && (state_q == ST_LOAD);
    assign start_s0    = start && (state_q == ST_STEP);
    assign start_s1    = start && ((state_q == ST_STEP) || (state_q == ST_CYC_STEP));
    assign init_state  = init_state_q;
    assign res_meet    = res_q.meet;
    assign res_period  = res_q.period;
    assign res_state   = res_q.state;
    assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: a 3-node network model driven by the
// controller's strobes, a directed vector table, corner sequences and random runs.
module tb_gnr_attractor_ctrl;

    localparam int NN = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // main instance (large step limit)
    logic          a_init_valid = 1'b0, a_init_ready, a_reset_nos, a_start_s0, a_start_s1;
    logic [NN-1:0] a_init_data = '0, a_init_state, a_res_state;
    logic [NN-1:0] a_s0 = '0, a_s1 = '0;
    logic          a_ph = 1'b0;
    logic          a_res_valid, a_res_ready = 1'b0, a_res_timeout;
    logic [CW-1:0] a_res_meet, a_res_period;

    // timeout instance (step limit 4)
    logic          b_init_valid = 1'b0, b_init_ready, b_reset_nos, b_start_s0, b_start_s1;
    logic [NN-1:0] b_init_data = '0, b_init_state, b_res_state;
    logic [NN-1:0] b_s0 = '0, b_s1 = '0;
    logic          b_ph = 1'b0;
    logic          b_res_valid, b_res_ready = 1'b0, b_res_timeout;
    logic [CW-1:0] b_res_meet, b_res_period;
    int            b_steps = 0;

    logic [NN-1:0] fa [8];

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(65535)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .init_valid(a_init_valid), .init_ready(a_init_ready), .init_data(a_init_data),
        .reset_nos(a_reset_nos), .init_state(a_init_state),
        .start_s0(a_start_s0), .start_s1(a_start_s1),
        .net_s0(a_s0), .net_s1(a_s1),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_meet(a_res_meet), .res_period(a_res_period),
        .res_state(a_res_state), .res_timeout(a_res_timeout)
    );

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(4)) u_to (
        .clk(clk), .rst(rst), .start(start),
        .init_valid(b_init_valid), .init_ready(b_init_ready), .init_data(b_init_data),
        .reset_nos(b_reset_nos), .init_state(b_init_state),
        .start_s0(b_start_s0), .start_s1(b_start_s1),
        .net_s0(b_s0), .net_s1(b_s1),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_meet(b_res_meet), .res_period(b_res_period),
        .res_state(b_res_state), .res_timeout(b_res_timeout)
    );

    // Node arrays: s0 advances on every second s0 strobe, s1 on every s1 strobe.
    always @(posedge clk) begin
        if (a_reset_nos) begin
            a_s0 <= a_init_state; a_s1 <= a_init_state; a_ph <= 1'b0;
        end else begin
            if (a_start_s0) begin
                if (!a_ph) a_s0 <= fa[a_s0];
                a_ph <= ~a_ph;
            end
            if (a_start_s1) a_s1 <= fa[a_s1];
        end
    end

    always @(posedge clk) begin
        if (b_reset_nos) begin
            b_s0 <= b_init_state; b_s1 <= b_init_state; b_ph <= 1'b0; b_steps <= 0;
        end else begin
            if (b_start_s0) begin
                if (!b_ph) b_s0 <= {b_s0[1:0], b_s0[2]};
                b_ph    <= ~b_ph;
                b_steps <= b_steps + 1;
            end
            if (b_start_s1) b_s1 <= {b_s1[1:0], b_s1[2]};
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the trajectory x_k = f^k(init); meet is the first even
    // k>=2 with x_k == x_{k/2}, period the first p>=1 with x_{meet+p} == x_meet.
    function automatic void ref_calc(input logic [NN-1:0] d, output int meet,
                                     output int per, output logic [NN-1:0] st);
        logic [NN-1:0] tr [64];
        tr[0] = d;
        for (int i = 1; i < 64; i++) tr[i] = fa[tr[i-1]];
        meet = 0;
        per  = 0;
        for (int k = 2; k < 32; k += 2)
            if (tr[k] == tr[k/2]) begin meet = k; break; end
        st = tr[meet];
        for (int p = 1; p <= 8; p++)
            if (tr[meet+p] == tr[meet]) begin per = p; break; end
    endfunction

    task automatic send_a(input logic [NN-1:0] d);
        int g;
        @(negedge clk);
        start = 1'b1;
        a_init_valid = 1'b1;
        a_init_data  = d;
        g = 0;
        while (!a_init_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) check("init_handshake_wait", 0, 1);
        @(negedge clk);
        a_init_valid = 1'b0;
    endtask

    // mode 0: start held high; 1: 5-cycle start gap; 2: random start drops
    task automatic run_a(input logic [NN-1:0] d, input int mode, output int lat);
        send_a(d);
        lat = 1;
        while (!a_res_valid && lat < 2000) begin
            if (mode == 1 && lat == 4) begin
                start = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    #1;
                    check("gap_strobes", {a_reset_nos, a_start_s0, a_start_s1}, 0);
                    @(negedge clk);
                end
                start = 1'b1;
            end
            if (mode == 2) start = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        if (!a_res_valid) check("res_valid_wait", 0, 1);
    endtask

    task automatic release_a(input int hold);
        logic [CW-1:0] m, p;
        logic [NN-1:0] s;
        m = a_res_meet; p = a_res_period; s = a_res_state;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", a_res_valid, 1);
            check("hold_init_ready", a_init_ready, 0);
            check("hold_fields", {a_res_meet, a_res_period, 5'd0, a_res_state}, {m, p, 5'd0, s});
        end
        a_res_ready = 1'b1;
        @(negedge clk);
        a_res_ready = 1'b0;
        check("release_valid", a_res_valid, 0);
        check("release_init_ready", a_init_ready, 1);
        check("idle_fields_kept", a_res_meet, m);
    endtask

    typedef struct {
        logic [NN-1:0] init;
        logic [CW-1:0] meet;
        logic [CW-1:0] period;
        logic [NN-1:0] state;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int lat, m, p, g;
        logic [NN-1:0] st, d;

        vecs[0] = '{init: 3'b001, meet: 16'd6, period: 16'd3, state: 3'b001};
        vecs[1] = '{init: 3'b000, meet: 16'd2, period: 16'd1, state: 3'b000};
        vecs[2] = '{init: 3'b111, meet: 16'd2, period: 16'd1, state: 3'b111};
        vecs[3] = '{init: 3'b011, meet: 16'd6, period: 16'd3, state: 3'b011};
        vecs[4] = '{init: 3'b010, meet: 16'd6, period: 16'd3, state: 3'b010};
        for (int i = 0; i < 8; i++) begin
            d = NN'(i);
            fa[i] = {d[1:0], d[2]};
        end

        repeat (3) @(negedge clk);
        check("rst_init_ready", a_init_ready, 1);
        check("rst_strobes", {a_reset_nos, a_start_s0, a_start_s1}, 0);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_fields", {a_res_meet, a_res_period, 5'd0, a_res_state}, 0);
        check("rst_timeout", a_res_timeout, 0);
        check("rst_init_state", a_init_state, 0);
        rst = 1'b0;
        start = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i].init, 0, lat);
            check("vec_meet", a_res_meet, vecs[i].meet);
            check("vec_period", a_res_period, vecs[i].period);
            check("vec_state", a_res_state, vecs[i].state);
            check("vec_timeout", a_res_timeout, 0);
            if (vecs[i].period == 1) check("fixed_point_latency", lat, 8);
            release_a(i == 0 ? 10 : 0);
        end

        run_a(3'b001, 1, lat);
        check("gap_meet", a_res_meet, 6);
        check("gap_period", a_res_period, 3);
        check("gap_state", a_res_state, 3'b001);
        release_a(1);

        send_a(3'b001);
        g = 0;
        while (!(a_start_s1 && !a_start_s0) && g < 200) begin @(negedge clk); g++; end
        check("reach_cyc_step", (g < 200), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_init_ready", a_init_ready, 1);
        check("abort_strobes", {a_reset_nos, a_start_s0, a_start_s1}, 0);
        check("abort_res_valid", a_res_valid, 0);
        check("abort_meet", a_res_meet, 0);
        rst = 1'b0;
        run_a(3'b011, 0, lat);
        check("after_abort_meet", a_res_meet, 6);
        check("after_abort_period", a_res_period, 3);
        check("after_abort_state", a_res_state, 3'b011);
        release_a(0);

        @(negedge clk);
        b_init_valid = 1'b1;
        b_init_data  = 3'b001;
        g = 0;
        while (!b_init_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        b_init_valid = 1'b0;
        g = 0;
        while (!b_res_valid && g < 200) begin @(negedge clk); g++; end
        check("to_valid", b_res_valid, 1);
        check("to_timeout", b_res_timeout, 1);
        check("to_period", b_res_period, 0);
        check("to_steps", b_steps, 4);
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready = 1'b0;
        check("to_release", {b_res_valid, b_init_ready}, 2'b01);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) fa[i] = NN'($urandom_range(0, 7));
            d = NN'($urandom_range(0, 7));
            ref_calc(d, m, p, st);
            run_a(d, 2, lat);
            check("rnd_meet", a_res_meet, m);
            check("rnd_period", a_res_period, p);
            check("rnd_state", a_res_state, st);
            check("rnd_timeout", a_res_timeout, 0);
            release_a($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1);
    end

endmodule
